// File: rtl/rx_frame_fsm_if.sv
// Block stream between the 64b/66b decoder and the MAC-facing side of rx_frame_fsm.
// The master drives the decoded block and flags; the slave returns the framed stream and counters.
interface rx_frame_fsm_if #(
  parameter bit IS_40G = 1'b0,
  parameter int DATA_W = 64,
  parameter int CNT_W  = 16
);
  localparam int KEEP_W      = DATA_W / 8;
  localparam int LANE0_CNT_N = IS_40G ? 1 : 2;

  logic                   block_lock_i;
  logic                   valid_i;
  logic                   ctrl_v_i;
  logic                   idle_v_i;
  logic                   term_v_i;
  logic                   err_v_i;
  logic                   ord_v_i;
  logic [LANE0_CNT_N-1:0] start_v_i;
  logic [DATA_W-1:0]      data_i;
  logic [KEEP_W-1:0]      keep_i;

  logic                   valid_o;
  logic [LANE0_CNT_N-1:0] start_o;
  logic                   term_o;
  logic                   err_o;
  logic [DATA_W-1:0]      data_o;
  logic [KEEP_W-1:0]      keep_o;
  logic [CNT_W-1:0]       frames_o;
  logic [CNT_W-1:0]       errs_o;

  modport master (
    output block_lock_i, valid_i, ctrl_v_i, idle_v_i, term_v_i, err_v_i, ord_v_i,
           start_v_i, data_i, keep_i,
    input  valid_o, start_o, term_o, err_o, data_o, keep_o, frames_o, errs_o
  );

  modport slave (
    input  block_lock_i, valid_i, ctrl_v_i, idle_v_i, term_v_i, err_v_i, ord_v_i,
           start_v_i, data_i, keep_i,
    output valid_o, start_o, term_o, err_o, data_o, keep_o, frames_o, errs_o
  );
endinterface

// File: rtl/rx_frame_fsm.sv
// Simplified clause-49 receive framing FSM: classifies decoded blocks, tracks frame
// boundaries and emits a registered MAC-facing stream with saturating frame/error counters.
module rx_frame_fsm #(
  parameter bit IS_40G = 1'b0,
  parameter int DATA_W = 64,
  parameter int CNT_W  = 16
) (
  input logic           clk,
  input logic           nreset,
  rx_frame_fsm_if.slave bus
);
  localparam int KEEP_W      = DATA_W / 8;
  localparam int LANE0_CNT_N = IS_40G ? 1 : 2;

  typedef enum logic [1:0] {RX_INIT, RX_C, RX_D, RX_E} state_t;
  typedef enum logic [2:0] {CLS_C, CLS_D, CLS_S, CLS_T, CLS_E} cls_t;

  state_t state, state_nxt;
  cls_t   cls;
  logic   accept;
  logic   start_l0, start_l4;

  logic                   valid_d, term_d, err_d, frame_inc, err_inc;
  logic [LANE0_CNT_N-1:0] start_d;
  logic [KEEP_W-1:0]      keep_d;

  logic                   valid_q, term_q, err_q;
  logic [LANE0_CNT_N-1:0] start_q;
  logic [KEEP_W-1:0]      keep_q;
  logic [DATA_W-1:0]      data_q;
  logic [CNT_W-1:0]       frames_q, errs_q;

  assign accept   = bus.block_lock_i && bus.valid_i;
  assign start_l0 = bus.start_v_i[0];
  // The 40G variant has no lane-4 start flag; the index collapses to bit 0 but is masked off.
  assign start_l4 = (LANE0_CNT_N > 1) && bus.start_v_i[LANE0_CNT_N-1];

  always_comb begin : classify
    if (bus.err_v_i)                       cls = CLS_E;
    else if (!bus.ctrl_v_i)                cls = CLS_D;
    else if (start_l0 || start_l4)         cls = (start_l0 && start_l4) ? CLS_E : CLS_S;
    else if (bus.term_v_i)                 cls = CLS_T;
    else if (bus.idle_v_i || bus.ord_v_i)  cls = CLS_C;
    else                                   cls = CLS_E;
  end

  // NOTE: non-blocking assignments for all clocked state so every register samples pre-edge values.
  always_ff @(posedge clk or negedge nreset) begin : state_reg
    if (!nreset) state <= RX_INIT;
    else         state <= state_nxt;
  end

  always_comb begin : next_state
    // NOTE: default assignment first so every path drives state_nxt and no latch is inferred.
    state_nxt = state;
    if (!bus.block_lock_i) begin
      state_nxt = RX_INIT;
    end else if (bus.valid_i) begin
      case (state)
        RX_D: begin
          case (cls)
            CLS_D:   state_nxt = RX_D;
            CLS_T:   state_nxt = RX_C;
            default: state_nxt = RX_E;
          endcase
        end
        default: begin
          case (cls)
            CLS_C:   state_nxt = RX_C;
            CLS_S:   state_nxt = RX_D;
            default: state_nxt = RX_E;
          endcase
        end
      endcase
    end
  end

  always_comb begin : output_dec
    valid_d   = 1'b0;
    start_d   = '0;
    term_d    = 1'b0;
    err_d     = 1'b0;
    keep_d    = '0;
    frame_inc = 1'b0;
    err_inc   = 1'b0;
    if (!bus.block_lock_i) begin
      // Losing lock mid-frame must be visible to the MAC as an aborted block.
      if (state == RX_D) begin
        valid_d = 1'b1;
        err_d   = 1'b1;
        err_inc = 1'b1;
      end
    end else if (bus.valid_i) begin
      valid_d = 1'b1;
      err_d   = (state_nxt == RX_E);
      err_inc = err_d && (state != RX_E);
      case (cls)
        CLS_D: keep_d = '1;
        CLS_S: begin
          start_d = bus.start_v_i;
          keep_d  = start_l0 ? ~KEEP_W'(1) : ~KEEP_W'(8'h1F);
        end
        CLS_T: begin
          term_d    = (state == RX_D);
          frame_inc = term_d;
          keep_d    = bus.keep_i << 1;
        end
        default: keep_d = '0;
      endcase
    end
  end

  always_ff @(posedge clk or negedge nreset) begin : out_reg
    if (!nreset) begin
      valid_q  <= 1'b0;
      start_q  <= '0;
      term_q   <= 1'b0;
      err_q    <= 1'b0;
      keep_q   <= '0;
      data_q   <= '0;
      frames_q <= '0;
      errs_q   <= '0;
    end else begin
      valid_q <= valid_d;
      start_q <= start_d;
      term_q  <= term_d;
      err_q   <= err_d;
      keep_q  <= keep_d;
      if (accept)                          data_q   <= bus.data_i;
      if (frame_inc && (frames_q != '1))   frames_q <= frames_q + CNT_W'(1);
      if (err_inc && (errs_q != '1))       errs_q   <= errs_q + CNT_W'(1);
    end
  end

  assign bus.valid_o  = valid_q;
  assign bus.start_o  = start_q;
  assign bus.term_o   = term_q;
  assign bus.err_o    = err_q;
  assign bus.keep_o   = keep_q;
  assign bus.data_o   = data_q;
  assign bus.frames_o = frames_q;
  assign bus.errs_o   = errs_q;
endmodule

// File: tb/tb_rx_frame_fsm.sv
// Bench for rx_frame_fsm: directed framing scenarios plus random blocks, checked against a
// rule-level reference model; a second instance with 4-bit counters covers saturation.
module tb_rx_frame_fsm;
  logic clk = 1'b0;
  logic nreset = 1'b0;
  always #5 clk = ~clk;

  rx_frame_fsm_if #(.IS_40G(1'b0), .DATA_W(64), .CNT_W(16)) bus_a ();
  rx_frame_fsm_if #(.IS_40G(1'b0), .DATA_W(64), .CNT_W(4))  bus_b ();

  rx_frame_fsm #(.IS_40G(1'b0), .DATA_W(64), .CNT_W(16)) dut_a (
    .clk(clk), .nreset(nreset), .bus(bus_a.slave));
  rx_frame_fsm #(.IS_40G(1'b0), .DATA_W(64), .CNT_W(4)) dut_b (
    .clk(clk), .nreset(nreset), .bus(bus_b.slave));

  int vectors = 0;
  int miscompares = 0;

  // Reference model: frame position as a letter (I=init, C=idle, D=in frame, E=error).
  byte         m_st;
  int          m_frames;
  int          m_errs;
  logic [63:0] m_data;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic int sat(input int v, input int w);
    return (v > (1 << w) - 1) ? (1 << w) - 1 : v;
  endfunction

  function automatic byte classify(input bit ctrl, idle, term, err, ord, input logic [1:0] start);
    if (err)              return "E";
    if (!ctrl)            return "D";
    if (start == 2'b11)   return "E";
    if (start != 2'b00)   return "S";
    if (term)             return "T";
    if (idle || ord)      return "C";
    return "E";
  endfunction

  task automatic model_reset();
    m_st = "I";
    m_frames = 0;
    m_errs = 0;
    m_data = '0;
  endtask

  task automatic check_counters(input string tag);
    check({tag, ".frames_a"}, 64'(bus_a.frames_o), 64'(sat(m_frames, 16)));
    check({tag, ".errs_a"},   64'(bus_a.errs_o),   64'(sat(m_errs, 16)));
    check({tag, ".frames_b"}, 64'(bus_b.frames_o), 64'(sat(m_frames, 4)));
    check({tag, ".errs_b"},   64'(bus_b.errs_o),   64'(sat(m_errs, 4)));
  endtask

  task automatic check_reset(input string tag);
    check({tag, ".valid"}, 64'(bus_a.valid_o), 64'(0));
    check({tag, ".start"}, 64'(bus_a.start_o), 64'(0));
    check({tag, ".term"},  64'(bus_a.term_o),  64'(0));
    check({tag, ".err"},   64'(bus_a.err_o),   64'(0));
    check({tag, ".keep"},  64'(bus_a.keep_o),  64'(0));
    check({tag, ".data"},  bus_a.data_o,       64'(0));
    check({tag, ".valid_b"}, 64'(bus_b.valid_o), 64'(0));
    check_counters(tag);
  endtask

  task automatic apply(input string tag, input bit lock, valid, ctrl, idle, term, err, ord,
                       input logic [1:0] start, input logic [63:0] data, input logic [7:0] keep);
    byte         cls, nxt;
    bit          e_valid, e_term, e_err, chk_blk, chk_data;
    logic [1:0]  e_start;
    logic [7:0]  e_keep;
    bus_a.block_lock_i = lock;  bus_b.block_lock_i = lock;
    bus_a.valid_i = valid;      bus_b.valid_i = valid;
    bus_a.ctrl_v_i = ctrl;      bus_b.ctrl_v_i = ctrl;
    bus_a.idle_v_i = idle;      bus_b.idle_v_i = idle;
    bus_a.term_v_i = term;      bus_b.term_v_i = term;
    bus_a.err_v_i = err;        bus_b.err_v_i = err;
    bus_a.ord_v_i = ord;        bus_b.ord_v_i = ord;
    bus_a.start_v_i = start;    bus_b.start_v_i = start;
    bus_a.data_i = data;        bus_b.data_i = data;
    bus_a.keep_i = keep;        bus_b.keep_i = keep;

    e_valid = 0; e_term = 0; e_err = 0; e_start = '0; e_keep = '0;
    chk_blk = 0; chk_data = 1;
    if (!lock) begin
      if (m_st == "D") begin
        e_valid = 1; e_err = 1; chk_blk = 1;
        m_errs++;
      end
      chk_data = 0;
      m_st = "I";
    end else if (valid) begin
      cls = classify(ctrl, idle, term, err, ord, start);
      if (m_st == "D") nxt = (cls == "D") ? "D" : (cls == "T") ? "C" : "E";
      else             nxt = (cls == "C") ? "C" : (cls == "S") ? "D" : "E";
      e_valid = 1; chk_blk = 1;
      e_start = (cls == "S") ? start : 2'b00;
      e_term  = (cls == "T") && (m_st == "D");
      e_err   = (nxt == "E");
      case (cls)
        "D":     e_keep = 8'hFF;
        "S":     e_keep = start[0] ? 8'hFE : 8'hE0;
        "T":     e_keep = keep << 1;
        default: e_keep = 8'h00;
      endcase
      if (e_term) m_frames++;
      if ((nxt == "E") && (m_st != "E")) m_errs++;
      m_data = data;
      m_st = nxt;
    end

    @(posedge clk);
    #1;
    check({tag, ".valid"},   64'(bus_a.valid_o), 64'(e_valid));
    check({tag, ".valid_b"}, 64'(bus_b.valid_o), 64'(e_valid));
    if (chk_blk) begin
      check({tag, ".start"}, 64'(bus_a.start_o), 64'(e_start));
      check({tag, ".term"},  64'(bus_a.term_o),  64'(e_term));
      check({tag, ".err"},   64'(bus_a.err_o),   64'(e_err));
      check({tag, ".keep"},  64'(bus_a.keep_o),  64'(e_keep));
      check({tag, ".err_b"}, 64'(bus_b.err_o),   64'(e_err));
    end
    if (chk_data) check({tag, ".data"}, bus_a.data_o, m_data);
    check_counters(tag);
  endtask

  function automatic logic [63:0] rnd64();
    return {$urandom, $urandom};
  endfunction

  task automatic c_blk(input string tag);
    apply(tag, 1, 1, 1, 1, 0, 0, 0, 2'b00, {rnd64() >> 8, 8'h1E}, 8'h00);
  endtask
  task automatic s_blk(input string tag, input bit lane4);
    apply(tag, 1, 1, 1, 0, 0, 0, 0, lane4 ? 2'b10 : 2'b01,
          {rnd64() >> 8, lane4 ? 8'h33 : 8'h78}, 8'h00);
  endtask
  task automatic d_blk(input string tag);
    apply(tag, 1, 1, 0, 0, 0, 0, 0, 2'b00, rnd64(), 8'h00);
  endtask
  task automatic t_blk(input string tag, input int n);
    logic [7:0] k;
    k = 8'((1 << n) - 1);
    apply(tag, 1, 1, 1, 0, 1, 0, 0, 2'b00, {rnd64() >> 8, 8'h87}, k);
  endtask
  task automatic gap(input string tag);
    apply(tag, 1, 0, 0, 0, 0, 0, 0, 2'b00, rnd64(), 8'h00);
  endtask
  task automatic lock_loss(input string tag);
    apply(tag, 0, 1, 0, 0, 0, 0, 0, 2'b00, rnd64(), 8'h00);
  endtask

  initial begin
    apply_idle_inputs();
    model_reset();
    #12;
    check_reset("reset");
    @(negedge clk);
    nreset = 1'b1;

    // Basic frame after idles.
    c_blk("t1_c"); c_blk("t1_c"); c_blk("t1_c");
    s_blk("t1_s0", 1'b0);
    d_blk("t1_d"); d_blk("t1_d");
    t_blk("t1_t3", 3);
    check("t1.frames_const", 64'(bus_a.frames_o), 64'(1));
    check("t1.errs_const",   64'(bus_a.errs_o),   64'(0));

    // Frame aborted by an idle block.
    s_blk("t2_s0", 1'b0); d_blk("t2_d");
    c_blk("t2_abort");
    check("t2.abort_keep", 64'(bus_a.keep_o), 64'(0));
    c_blk("t2_recover");
    check("t2.errs_const", 64'(bus_a.errs_o), 64'(1));

    // valid_i gaps inside a frame.
    s_blk("t3_s0", 1'b0); gap("t3_gap");
    d_blk("t3_d");        gap("t3_gap");
    d_blk("t3_d");        gap("t3_gap");
    t_blk("t3_t3", 3);    gap("t3_gap");
    check("t3.frames_const", 64'(bus_a.frames_o), 64'(2));

    // Lock lost for one cycle mid-frame, then recovery only through idle/start.
    s_blk("t4_s0", 1'b0); d_blk("t4_d");
    lock_loss("t4_lock");
    d_blk("t4_d_after"); t_blk("t4_t_after", 2);
    check("t4.errs_const",   64'(bus_a.errs_o),   64'(3));
    check("t4.frames_const", 64'(bus_a.frames_o), 64'(2));
    c_blk("t4_c"); s_blk("t4_s0", 1'b0); d_blk("t4_d"); t_blk("t4_t5", 5);

    // Lane-4 start, T7, and back-to-back T then S.
    s_blk("t5_s4", 1'b1);
    check("t5.keep_e0", 64'(bus_a.keep_o), 64'(8'hE0));
    d_blk("t5_d");
    t_blk("t5_t7", 7);
    check("t5.keep_fe", 64'(bus_a.keep_o), 64'(8'hFE));
    s_blk("t5_b2b_s0", 1'b0); d_blk("t5_d"); t_blk("t5_t0", 0);
    check("t5.frames_const", 64'(bus_a.frames_o), 64'(5));

    // Counter saturation: 20 good frames then 20 separate error events.
    for (int i = 0; i < 20; i++) begin
      s_blk("t6_s", 1'b0); d_blk("t6_d"); t_blk("t6_t", 1);
    end
    for (int i = 0; i < 20; i++) begin
      d_blk("t6_err"); c_blk("t6_c");
    end
    check("t6.frames_sat", 64'(bus_b.frames_o), 64'(4'hF));
    check("t6.errs_sat",   64'(bus_b.errs_o),   64'(4'hF));

    // Random blocks against the model.
    for (int i = 0; i < 1500; i++) begin
      int kind;
      kind = int'($urandom_range(0, 9));
      if ($urandom_range(0, 24) == 0)      lock_loss("rnd_lock");
      else if ($urandom_range(0, 4) == 0)  gap("rnd_gap");
      else if (kind < 2)                   c_blk("rnd_c");
      else if (kind < 3)                   s_blk("rnd_s", 1'($urandom_range(0, 1)));
      else if (kind < 6)                   d_blk("rnd_d");
      else if (kind < 8)                   t_blk("rnd_t", int'($urandom_range(0, 7)));
      else
        apply("rnd_raw", 1, 1, 1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom_range(0, 3) == 0),
              1'($urandom), 2'($urandom), rnd64(), 8'($urandom));
    end

    // Asynchronous reset in the middle of a frame.
    c_blk("t8_c"); s_blk("t8_s0", 1'b0); d_blk("t8_d");
    #2;
    nreset = 1'b0;
    model_reset();
    #1;
    check_reset("t8_async_reset");
    @(negedge clk);
    nreset = 1'b1;
    c_blk("t8_c"); s_blk("t8_s0", 1'b0); d_blk("t8_d"); t_blk("t8_t4", 4);
    check("t8.frames_const", 64'(bus_a.frames_o), 64'(1));

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  task automatic apply_idle_inputs();
    bus_a.block_lock_i = 1'b1; bus_b.block_lock_i = 1'b1;
    bus_a.valid_i = 1'b0;      bus_b.valid_i = 1'b0;
    bus_a.ctrl_v_i = 1'b0;     bus_b.ctrl_v_i = 1'b0;
    bus_a.idle_v_i = 1'b0;     bus_b.idle_v_i = 1'b0;
    bus_a.term_v_i = 1'b0;     bus_b.term_v_i = 1'b0;
    bus_a.err_v_i = 1'b0;      bus_b.err_v_i = 1'b0;
    bus_a.ord_v_i = 1'b0;      bus_b.ord_v_i = 1'b0;
    bus_a.start_v_i = 2'b00;   bus_b.start_v_i = 2'b00;
    bus_a.data_i = '0;         bus_b.data_i = '0;
    bus_a.keep_i = '0;         bus_b.keep_i = '0;
  endtask
endmodule
